// File: rtl/phase_pkg.sv
// Shared types and helpers for the two-phase bundled-data channel endpoints.
package phase_pkg;

  typedef logic phase_t;

  localparam phase_t PHASE_INIT = 1'b0;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/phase_sync.sv
// Flop-chain synchroniser for a two-phase request/ack line; resets to the channel phase.
module phase_sync
  import phase_pkg::*;
#(
  parameter int     SYNC_STAGES = 2,
  parameter phase_t INIT        = PHASE_INIT
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= {SYNC_STAGES{INIT}};
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/phase_rx.sv
// Two-phase bundled-data receiver: synchronises req_in, captures data_in into a
// fall-through FIFO, toggles ack_out per captured word, presents a valid/ready stream.
module phase_rx
  import phase_pkg::*;
#(
  parameter int     WIDTH       = 8,
  parameter int     DEPTH       = 4,
  parameter int     SYNC_STAGES = 2,
  parameter phase_t INIT        = PHASE_INIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_in,
  input  logic [WIDTH-1:0]          data_in,
  output logic                      ack_out,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic             req_s;
  logic             ack_r;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  phase_sync #(.SYNC_STAGES(SYNC_STAGES), .INIT(INIT)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_in),
    .q   (req_s)
  );

  // Registered count only: a same-cycle pop does not open a slot for this push.
  assign push      = (req_s ^ ack_r) && (count < CW'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];
  assign ack_out   = ack_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r <= INIT;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= data_in;
        wptr      <= wptr + AW'(1);
        ack_r     <= ~ack_r;
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_rx.sv
// Scoreboard bench for phase_rx: a two-phase sender model drives words, a monitor
// checks every accepted output word against the queue of words sent.
module tb_phase_rx;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_in = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             ack_out;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];
  bit   track_en = 1'b0;
  int   max_cnt  = 0;

  phase_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .INIT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_out   (ack_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Output monitor: samples 1 ns before each rising edge, inputs are driven at falling edges.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (track_en && int'(count) > max_cnt) max_cnt = int'(count);
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %h, scoreboard empty", out_data);
        end else begin
          logic [WIDTH-1:0] exp_w;
          exp_w = sb.pop_front();
          if (out_data !== exp_w) begin
            errors++;
            $display("FAIL pop_data: got %h, expected %h", out_data, exp_w);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sender model: one toggle, returns negedges until ack moves (3 = ack at 2nd edge after sample), -1 on timeout.
  task automatic handshake(input logic [WIDTH-1:0] w, output int cyc);
    logic prev;
    @(negedge clk);
    data_in = w;
    prev    = ack_out;
    req_in  = ~req_in;
    sb.push_back(w);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack_out !== prev) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_in = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (ack_out !== 1'b0)   begin errors++; $display("FAIL reset_ack: got %b, expected 0", ack_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count: got %0d, expected 0", count); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", out_data); end
  endtask

  task automatic test_single();
    int cyc;
    out_ready = 1'b0;
    handshake(8'hA5, cyc);
    checks++; if (cyc !== 3)          begin errors++; $display("FAIL single_latency: got %0d, expected 3", cyc); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, expected 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h, expected a5", out_data); end
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL single_count: got %0d, expected 1", count); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL single_drain: got %0d, expected 0", count); end
  endtask

  task automatic test_full();
    int   cyc;
    logic prev;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      handshake(WIDTH'(k), cyc);
      checks++; if (cyc !== 3) begin errors++; $display("FAIL full_ack%0d: got %0d, expected 3", k, cyc); end
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d, expected 4", count); end
    @(negedge clk);
    data_in = 8'h05;
    prev    = ack_out;
    req_in  = ~req_in;
    sb.push_back(8'h05);
    repeat (6) @(negedge clk);
    checks++; if (ack_out !== prev) begin errors++; $display("FAIL full_held_ack: got %b, expected %b", ack_out, prev); end
    checks++; if (count !== 3'd4)   begin errors++; $display("FAIL full_held_count: got %0d, expected 4", count); end
    // Pop with a push pending: pop only this edge, capture on the next.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (count !== 3'd3)   begin errors++; $display("FAIL full_pop_count: got %0d, expected 3", count); end
    checks++; if (ack_out !== prev) begin errors++; $display("FAIL full_pop_ack: got %b, expected %b", ack_out, prev); end
    @(negedge clk);
    checks++; if (count !== 3'd4)   begin errors++; $display("FAIL full_cap_count: got %0d, expected 4", count); end
    checks++; if (ack_out === prev) begin errors++; $display("FAIL full_cap_ack: got %b, expected %b", ack_out, ~prev); end
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    out_ready = 1'b0;
    checks++; if (count !== 3'd0)   begin errors++; $display("FAIL full_drain_count: got %0d, expected 0", count); end
    checks++; if (sb.size() != 0)   begin errors++; $display("FAIL full_drain_sb: got %0d left, expected 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int bad = 0;
    out_ready = 1'b1;
    max_cnt   = 0;
    track_en  = 1'b1;
    for (int k = 0; k < 11; k++) begin
      handshake(WIDTH'($urandom_range(0, 255)), cyc);
      if (cyc < 0) bad++;
    end
    repeat (3) @(negedge clk);
    track_en  = 1'b0;
    out_ready = 1'b0;
    checks++; if (bad != 0)       begin errors++; $display("FAIL b2b_timeouts: got %0d, expected 0", bad); end
    checks++; if (max_cnt > 1)    begin errors++; $display("FAIL b2b_max_count: got %0d, expected <=1", max_cnt); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain_sb: got %0d left, expected 0", sb.size()); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_count: got %0d, expected 0", count); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    out_ready = 1'b0;
    req_in    = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    handshake(8'h11, cyc);
    handshake(8'h22, cyc);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL mid_pre_count: got %0d, expected 2", count); end
    @(negedge clk);
    data_in = 8'h77;
    req_in  = ~req_in;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b, expected 0", out_valid); end
    checks++; if (ack_out !== 1'b0)   begin errors++; $display("FAIL mid_rst_ack: got %b, expected 0", ack_out); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL mid_rst_count: got %0d, expected 0", count); end
    repeat (2) @(negedge clk);
    sb.push_back(8'h77);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ack_out !== 1'b0)   begin errors++; $display("FAIL mid_early_ack: got %b, expected 0", ack_out); end
    @(negedge clk);
    checks++; if (ack_out !== 1'b1)   begin errors++; $display("FAIL mid_cap_ack: got %b, expected 1", ack_out); end
    checks++; if (count !== 3'd1)     begin errors++; $display("FAIL mid_cap_count: got %0d, expected 1", count); end
    checks++; if (out_data !== 8'h77) begin errors++; $display("FAIL mid_cap_data: got %h, expected 77", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (sb.size() != 0)     begin errors++; $display("FAIL mid_drain_sb: got %0d left, expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
